// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use interlock, execute-stage redirect flush,
// data-memory wait stalls with a sticky watchdog. HAZARD_PERF_CNT_EN adds stall/flush counters.
module hazard_ctrl #(
  parameter int unsigned WD_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] inst_d,
  input  logic [31:0] inst_x,
  input  logic        br_taken_x,
  input  logic        mem_busy,
  output logic        stall_f,
  output logic        stall_d,
  output logic        stall_x,
  output logic        stall_m,
  output logic        flush_d,
  output logic        bubble_x,
  output logic        bubble_w,
  output logic        mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [15:0] WD_LIMIT = 16'(WD_CYCLES);

  state_t      state, next_state;
  logic [15:0] wait_cnt, wait_nxt;
  logic        load_use;

  function automatic logic uses_rs1(input logic [4:0] op);
    return (op == 5'b01100) || (op == 5'b00100) || (op == 5'b00000) ||
           (op == 5'b01000) || (op == 5'b11000) || (op == 5'b11001);
  endfunction

  function automatic logic uses_rs2(input logic [4:0] op);
    return (op == 5'b01100) || (op == 5'b01000) || (op == 5'b11000);
  endfunction

  // Encoding fields this block never looks at.
  logic unused_inst;
  assign unused_inst = ^{inst_d[31:25], inst_d[14:7], inst_d[1:0], inst_x[31:12], inst_x[1:0]};

  always_comb begin
    load_use = 1'b0;
    if ((inst_x[6:2] == OP_LOAD) && (inst_x[11:7] != 5'd0)) begin
      load_use = (uses_rs1(inst_d[6:2]) && (inst_d[19:15] == inst_x[11:7])) ||
                 (uses_rs2(inst_d[6:2]) && (inst_d[24:20] == inst_x[11:7]));
    end
  end

  always_comb begin
    // NOTE: every output and next-state variable gets a default first so no path infers a latch.
    next_state  = state;
    wait_nxt    = wait_cnt;
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_x     = 1'b0;
    stall_m     = 1'b0;
    flush_d     = 1'b0;
    bubble_x    = 1'b0;
    bubble_w    = 1'b0;
    mem_timeout = 1'b0;

    if ((state == ERROR) || mem_busy) begin
      // Frozen pipeline; branch and load-use are re-evaluated once memory releases.
      stall_f  = 1'b1;
      stall_d  = 1'b1;
      stall_x  = 1'b1;
      stall_m  = 1'b1;
      bubble_w = 1'b1;
    end else if (br_taken_x) begin
      flush_d  = 1'b1;
      bubble_x = 1'b1;
    end else if (load_use) begin
      stall_f  = 1'b1;
      stall_d  = 1'b1;
      bubble_x = 1'b1;
    end

    case (state)
      RUN: begin
        if (mem_busy) begin
          next_state = MEM_WAIT;
          wait_nxt   = (wait_cnt == 16'hFFFF) ? wait_cnt : wait_cnt + 16'd1;
        end
      end
      MEM_WAIT: begin
        if (mem_busy) begin
          if (wait_cnt == WD_LIMIT) next_state = ERROR;
          wait_nxt = (wait_cnt == 16'hFFFF) ? wait_cnt : wait_cnt + 16'd1;
        end else begin
          next_state = RUN;
          wait_nxt   = 16'd0;
        end
      end
      ERROR:   mem_timeout = 1'b1;
      default: next_state = RUN;
    endcase

    // Outputs are quiet for the whole reset assertion, not only after the state clears.
    if (!reset_n) begin
      stall_f     = 1'b0;
      stall_d     = 1'b0;
      stall_x     = 1'b0;
      stall_m     = 1'b0;
      flush_d     = 1'b0;
      bubble_x    = 1'b0;
      bubble_w    = 1'b0;
      mem_timeout = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RUN;
      wait_cnt <= 16'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
      state    <= next_state;
      wait_cnt <= wait_nxt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (stall_f && (state != ERROR)) stall_cnt <= stall_cnt + 32'd1;
      if (flush_d)                     flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule
